// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
//   pc_sel_t      : PC source select (sequential, branch target, exception vector)
//   REG_D..REG_W  : bit index of each inter-stage register in the control vectors
//                   (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB)
//   ctrl_state_t  : controller state (normal run, post-exception drain)
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        SEQ        = 2'd0,
        BRANCH     = 2'd1,
        EXC_VECTOR = 2'd2
    } pc_sel_t;

    localparam int REG_D    = 0;
    localparam int REG_E    = 1;
    localparam int REG_M    = 2;
    localparam int REG_W    = 3;
    localparam int NUM_REGS = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of hazard inputs and hold/nullify/PC controls between the pipeline
// and its controller.
//   master : the controller (consumes hazard requests, drives controls)
//   slave  : the pipeline datapath (raises hazard requests, obeys controls)
// Vector bit index follows REG_D/REG_E/REG_M/REG_W from pipeline_ctrl_pkg.
interface pipeline_controller_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic              load_use_hazard;
    logic              ex_busy;
    logic              mem_wait;
    logic              redirect_valid;
    logic              exception_valid;
    logic              pc_stall;
    pc_sel_t           pc_sel;
    logic [3:0]        stall;
    logic [3:0]        bubble;
    logic [3:0]        nullify;
    logic              redirect_ack;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        input  load_use_hazard, ex_busy, mem_wait, redirect_valid, exception_valid,
        output pc_stall, pc_sel, stall, bubble, nullify, redirect_ack, mem_timeout,
               stall_count
    );

    modport slave (
        output load_use_hazard, ex_busy, mem_wait, redirect_valid, exception_valid,
        input  pc_stall, pc_sel, stall, bubble, nullify, redirect_ack, mem_timeout,
               stall_count
    );
endinterface

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-low reset
//   inc        : count up by one (ignored once saturated)
//   clr        : synchronous clear, wins over inc
//   count      : current value
//   saturated  : count has reached MAX
module sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         saturated
);
    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign saturated = (count_reg == MAX);
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !saturated) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/pipeline_controller.sv
// Hazard and flush sequencer for the 5-stage core.
// Decides, every cycle, which inter-stage registers hold (stall = own stage is
// the cause, bubble = held because a later stage holds), which load a nullified
// instruction, whether the PC holds and where it comes from. Priority:
// exception > mem_wait > ex_busy > redirect > load-use. After an exception the
// PC is held and IF/ID nullified for EXC_DRAIN_CYCLES cycles (DRAIN state).
// Also hosts a mem_wait watchdog and a saturating count of PC-stall cycles.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : pipeline_controller_if.master (hazards in, controls out)
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int EXC_DRAIN_CYCLES   = 2,
    parameter int MEM_TIMEOUT_CYCLES = 255,
    parameter int CNT_W              = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_controller_if.master        bus
);
    localparam logic [3:0]  DRAIN_LOAD = 4'(EXC_DRAIN_CYCLES);
    localparam logic [15:0] WD_LIMIT   = 16'(MEM_TIMEOUT_CYCLES);
    localparam logic [15:0] WD_LAST    = 16'(MEM_TIMEOUT_CYCLES - 1);

    ctrl_state_t state_reg;
    logic [3:0]  drain_reg;

    // Rules 2..5, evaluated independently of state; the state decides below
    // which parts of the result reach the outputs.
    logic [3:0] stall_rule;
    logic [3:0] bubble_rule;
    logic [3:0] nullify_rule;
    logic       pc_stall_rule;
    logic       ack_rule;
    pc_sel_t    sel_rule;

    logic take_exc;
    logic draining;

    logic [3:0] stall_out;
    logic [3:0] bubble_out;
    logic [3:0] nullify_out;
    logic       pc_stall_out;

    logic [15:0]      wd_count;
    logic             wd_sat;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_sat;

    assign take_exc = (state_reg == RUN) && bus.exception_valid;
    assign draining = (state_reg == DRAIN);

    always_comb begin
        stall_rule    = '0;
        bubble_rule   = '0;
        nullify_rule  = '0;
        pc_stall_rule = 1'b0;
        ack_rule      = 1'b0;
        sel_rule      = SEQ;
        if (bus.mem_wait) begin
            stall_rule[REG_M]   = 1'b1;
            bubble_rule[REG_E]  = 1'b1;
            bubble_rule[REG_D]  = 1'b1;
            nullify_rule[REG_W] = 1'b1;
            pc_stall_rule       = 1'b1;
        end else if (bus.ex_busy) begin
            stall_rule[REG_E]   = 1'b1;
            bubble_rule[REG_D]  = 1'b1;
            nullify_rule[REG_M] = 1'b1;
            pc_stall_rule       = 1'b1;
        end else if (bus.redirect_valid) begin
            // Wrong-path D instruction is squashed, so a concurrent load-use
            // hazard is irrelevant and never reached.
            nullify_rule[REG_E] = 1'b1;
            nullify_rule[REG_D] = 1'b1;
            sel_rule            = BRANCH;
            ack_rule            = 1'b1;
        end else if (bus.load_use_hazard) begin
            stall_rule[REG_D]   = 1'b1;
            nullify_rule[REG_E] = 1'b1;
            pc_stall_rule       = 1'b1;
        end
    end

    // Per-register output shaping. An exception flushes everything; DRAIN owns
    // IF/ID (forced nullify, no hold) and leaves downstream registers to the
    // rules. Reset low forces the flush pattern regardless of state.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == REG_D) begin : g_front
                assign stall_out[gi]   = reset & ~take_exc & ~draining & stall_rule[gi];
                assign bubble_out[gi]  = reset & ~take_exc & ~draining & bubble_rule[gi];
                assign nullify_out[gi] = ~reset | take_exc | draining | nullify_rule[gi];
            end else begin : g_down
                assign stall_out[gi]   = reset & ~take_exc & stall_rule[gi];
                assign bubble_out[gi]  = reset & ~take_exc & bubble_rule[gi];
                assign nullify_out[gi] = ~reset | take_exc | nullify_rule[gi];
            end
        end
    endgenerate

    assign pc_stall_out = ~reset | (~take_exc & (draining | pc_stall_rule));

    assign bus.stall    = stall_out;
    assign bus.bubble   = bubble_out;
    assign bus.nullify  = nullify_out;
    assign bus.pc_stall = pc_stall_out;
    assign bus.pc_sel   = !reset   ? SEQ        :
                          take_exc ? EXC_VECTOR :
                          draining ? SEQ        : sel_rule;
    // The PC is frozen while draining, so a redirect then stays pending.
    assign bus.redirect_ack = reset & ~take_exc & ~draining & ack_rule;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            drain_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.exception_valid) begin
                        state_reg <= DRAIN;
                        drain_reg <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    // exception_valid is ignored here.
                    drain_reg <= drain_reg - 4'd1;
                    if (drain_reg <= 4'd1) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    drain_reg <= '0;
                end
            endcase
        end
    end

    // Watchdog: counts consecutive mem_wait cycles and parks at the limit.
    // The pulse marks the cycle whose edge brings the count to the limit.
    sat_counter #(
        .W   (16),
        .MAX (WD_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .inc       (bus.mem_wait),
        .clr       (~bus.mem_wait),
        .count     (wd_count),
        .saturated (wd_sat)
    );

    assign bus.mem_timeout = reset & bus.mem_wait & ~wd_sat & (wd_count == WD_LAST);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (pc_stall_out & ~stall_sat),
        .clr       (1'b0),
        .count     (stall_cnt),
        .saturated (stall_sat)
    );

    assign bus.stall_count = stall_cnt;
endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and flush sequencer for the 5-stage core. Each cycle it drives hold and nullify controls for the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It resolves load-use hazards, multi-cycle execute, memory wait, branch redirect and exceptions by fixed priority. It also runs a post-exception drain FSM, a memory-wait timeout watchdog and a stall-cycle performance counter.

## Interface
Parameters:
- `EXC_DRAIN_CYCLES`, default 2: cycles the PC is held after an exception flush (1..15).
- `MEM_TIMEOUT_CYCLES`, default 255: consecutive `mem_wait` cycles before `mem_timeout` fires (1..65535).
- `CNT_W`, default 32: width of `stall_count`.

Ports (register vector index: 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB):
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `load_use_hazard` in 1: D-stage instruction needs a load result not yet available.
- `ex_busy` in 1: multi-cycle unit in E has not finished.
- `mem_wait` in 1: M-stage access not complete this cycle.
- `redirect_valid` in 1: E-stage branch mispredicted. The source holds it until it is accepted.
- `exception_valid` in 1: M-stage instruction raised an exception.
- `pc_stall` out 1: hold PC.
- `pc_sel` out 2: PC source. SEQ=0, BRANCH=1, EXC_VECTOR=2.
- `stall` out 4: register holds because its own stage originates the hold.
- `bubble` out 4: register holds because a downstream stage is holding.
- `nullify` out 4: register loads nullified control.
- `redirect_ack` out 1: redirect accepted this cycle.
- `mem_timeout` out 1: one-cycle pulse from the watchdog.
- `stall_count` out CNT_W: saturating count of cycles with `pc_stall`=1.

## Operation
- States are RUN and DRAIN.
- Control outputs are combinational from the inputs and the current state. The first matching rule applies; any bit not set by the rule is 0.
- While `reset`=0: `nullify`=4'b1111, `pc_stall`=1, all other control outputs 0.
- Rule 1, `exception_valid` in RUN: `nullify`=4'b1111, `pc_sel`=EXC_VECTOR, `pc_stall`=0. Next state is DRAIN and the drain counter loads `EXC_DRAIN_CYCLES`.
- Rule 2, `mem_wait`: `stall[2]`=1, `bubble[1:0]`=2'b11, `pc_stall`=1, `nullify[3]`=1.
- Rule 3, `ex_busy`: `stall[1]`=1, `bubble[0]`=1, `pc_stall`=1, `nullify[2]`=1.
- Rule 4, `redirect_valid`: `nullify[1:0]`=2'b11, `pc_sel`=BRANCH, `redirect_ack`=1. This rule overrides a concurrent `load_use_hazard`, because the D-stage instruction is wrong-path.
- Rule 5, `load_use_hazard`: `stall[0]`=1, `pc_stall`=1, `nullify[1]`=1.
- Rule 6: all outputs 0, `pc_sel`=SEQ.
- DRAIN state:
  - `pc_stall`=1 and `nullify[0]`=1. Rules 2–5 apply to downstream registers only.
  - The counter decrements each cycle; the state returns to RUN after the cycle in which it reads 1.
  - `exception_valid` in DRAIN is ignored. A bench assertion flags it as illegal.
- Watchdog:
  - A 16-bit counter increments on each `mem_wait` cycle and clears when `mem_wait`=0.
  - When it reaches `MEM_TIMEOUT_CYCLES`, `mem_timeout` pulses for exactly one cycle. The counter then saturates, so there is no re-fire until `mem_wait` drops.
- `stall_count` increments on every clock with `pc_stall`=1 and `reset`=1. It saturates at all-ones.

## Timing
- Control outputs take effect at the next rising `clk` edge: zero-cycle decision, one-cycle effect.
- Reset values: state RUN, drain counter 0, watchdog 0, `mem_timeout` 0, `stall_count` 0.
- Reset asserted mid-DRAIN returns to RUN immediately.
- `redirect_ack` is only high in a cycle where E advances, so a redirect during a stall is deferred, not lost.
- An exception coinciding with `mem_wait` is taken; the waiting access is nullified into W.
- With `EXC_DRAIN_CYCLES`=2, exception at cycle N gives DRAIN in cycles N+1 and N+2, RUN at N+3.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the `pc_sel_t` enum (SEQ, BRANCH, EXC_VECTOR);
  - the stage index constants (`REG_D`=0, `REG_E`=1, `REG_M`=2, `REG_W`=3);
  - the `ctrl_state_t` enum (RUN, DRAIN).
- One sub-module, `sat_counter` (parameterised width, increment, clear, saturate flag), instanced for the watchdog and for `stall_count`.

## Test plan
- Reset low for 3 cycles, release → `nullify`=4'hF during reset, then all 0, `stall_count`=0, `pc_sel`=SEQ.
- `load_use_hazard`=1 for 1 cycle → `stall`=4'b0001, `nullify`=4'b0010, `pc_stall`=1; `stall_count`=1 afterwards.
- `mem_wait` for 3 cycles together with `redirect_valid` → `stall`=4'b0100, `bubble`=4'b0011, `nullify`=4'b1000 for 3 cycles, `redirect_ack`=0. Cycle 4: `redirect_ack`=1, `pc_sel`=BRANCH, `nullify`=4'b0011.
- `exception_valid` plus `mem_wait` at cycle N → `nullify`=4'hF, `pc_sel`=EXC_VECTOR. Cycles N+1 and N+2: `pc_stall`=1, `nullify[0]`=1. RUN at N+3. `exception_valid` pulsed at N+1 is ignored.
- `MEM_TIMEOUT_CYCLES`=4, `mem_wait` held for 10 cycles → single `mem_timeout` pulse on the 4th cycle; `stall_count`=10.
- Reset asserted during DRAIN → outputs take reset values immediately; first cycle after release is RUN with `pc_stall`=0.
